// File: rtl/sum_engine_arbiter.sv
// sum_engine_arbiter: round-robin sharing of one sum_N_nos engine.
// Optional watchdog on the engine handshake: define SUM_ARB_TIMEOUT_EN.
module sum_engine_arbiter #(
    parameter int NREQ      = 4,
    parameter int NW        = 3,
    parameter int SW        = 5,
    parameter int TO_CYCLES = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*NW-1:0] req_n,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [SW-1:0]      rsp_sum,
    output logic               rsp_err,
    input  logic [NREQ-1:0]    rsp_ack,
    output logic               eng_N_valid,
    output logic [NW-1:0]      eng_N_in,
    input  logic               eng_ready,
    input  logic               eng_sum_valid,
    input  logic [SW-1:0]      eng_sum,
    output logic               eng_ack,
    output logic               busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK,
        S_RESP
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] id_q;
    logic [IW-1:0] win_id;
    logic [IW-1:0] cand;
    logic          win_found;
    logic [NW-1:0] n_q;
    logic          to_hit;
    logic          to_fire;

    // Round-robin search starting just past the last served requester
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(rr_ptr) + k) % NREQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

`ifdef SUM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYCLES + 1);

    logic [CW-1:0] to_cnt;

    // Watchdog: restarts on each grant, counts while the engine owes us
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (state == S_IDLE && win_found) begin
            to_cnt <= '0;
        end else if ((state == S_ISSUE || state == S_WAIT) && !to_hit) begin
            to_cnt <= to_cnt + CW'(1);
        end
    end

    assign to_hit = (state == S_ISSUE || state == S_WAIT) &&
                    (to_cnt == CW'(TO_CYCLES - 1));
`else
    // No watchdog: this comparison is constant false
    assign to_hit = (TO_CYCLES < 0);
`endif

    // Timeout only wins when the engine handshake did not progress
    assign to_fire = to_hit &&
                     ((state == S_ISSUE && !eng_ready) ||
                      (state == S_WAIT && !eng_sum_valid));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and engine/response strobes
    always_comb begin
        state_nx    = state;
        eng_N_valid = 1'b0;
        eng_N_in    = '0;
        eng_ack     = 1'b0;
        rsp_valid   = '0;
        busy        = (state != S_IDLE);
        unique case (state)
            S_IDLE: begin
                if (win_found) state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                eng_N_valid = 1'b1;
                eng_N_in    = n_q;
                if (eng_ready) state_nx = S_WAIT;
                else if (to_fire) state_nx = S_RESP;
            end
            S_WAIT: begin
                if (eng_sum_valid) state_nx = S_ACK;
                else if (to_fire) state_nx = S_RESP;
            end
            S_ACK: begin
                eng_ack  = 1'b1;
                state_nx = S_RESP;
            end
            S_RESP: begin
                rsp_valid[id_q] = 1'b1;
                if (rsp_ack[id_q]) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Transaction context: owner, N, result, error and round-robin pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr    <= IW'(NREQ - 1);
            id_q      <= '0;
            n_q       <= '0;
            rsp_sum   <= '0;
            rsp_err   <= 1'b0;
            req_ready <= '0;
        end else begin
            req_ready <= '0;
            if (state == S_IDLE && win_found) begin
                id_q              <= win_id;
                n_q               <= req_n[int'(win_id)*NW +: NW];
                req_ready[win_id] <= 1'b1;
            end
            if (state == S_WAIT && eng_sum_valid) begin
                rsp_sum <= eng_sum;
            end
            if (to_fire) begin
                rsp_sum <= '0;
                rsp_err <= 1'b1;
            end
            if (state == S_RESP && rsp_ack[id_q]) begin
                rr_ptr  <= id_q;
                rsp_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sum_engine_arbiter.sv
// tb_sum_engine_arbiter: random traffic against a queue model of the
// round-robin arbiter, with a behavioural sum engine on the other side.
module tb_sum_engine_arbiter;

    localparam int NREQ      = 4;
    localparam int NW        = 3;
    localparam int SW        = 5;
    localparam int TO_CYCLES = 32;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*NW-1:0] req_n = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [SW-1:0]      rsp_sum;
    logic               rsp_err;
    logic [NREQ-1:0]    rsp_ack = '0;
    logic               eng_N_valid;
    logic [NW-1:0]      eng_N_in;
    logic               eng_ready = 1'b0;
    logic               eng_sum_valid = 1'b0;
    logic [SW-1:0]      eng_sum = '0;
    logic               eng_ack;
    logic               busy;

    int cmp_cnt = 0;
    int bad_cnt = 0;
    int last_owner = NREQ - 1;
    int qbuf [NREQ][16];
    int qhead [NREQ];
    int qlen [NREQ];
    int olog [$];
    int sum_log [$];
    int hold_log [$];
    bit eng_dead = 1'b0;
    bit noise_en = 1'b0;
    int e_st = 0;
    int e_dly = 0;
    int e_n = 0;

    sum_engine_arbiter #(
        .NREQ(NREQ), .NW(NW), .SW(SW), .TO_CYCLES(TO_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_n(req_n),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_sum(rsp_sum),
        .rsp_err(rsp_err),
        .rsp_ack(rsp_ack),
        .eng_N_valid(eng_N_valid),
        .eng_N_in(eng_N_in),
        .eng_ready(eng_ready),
        .eng_sum_valid(eng_sum_valid),
        .eng_sum(eng_sum),
        .eng_ack(eng_ack),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural engine: random ready, random compute delay, optional
    // stray sum_valid pulses while the arbiter is idle.
    always @(negedge clk) begin
        if (!reset) begin
            e_st = 0;
            eng_ready = 1'b0;
            eng_sum_valid = 1'b0;
            eng_sum = '0;
        end else begin
            case (e_st)
                0: begin
                    eng_sum_valid = 1'b0;
                    eng_ready = 1'b0;
                    if (eng_N_valid) begin
                        if ($urandom_range(0, 2) != 0) begin
                            eng_ready = 1'b1;
                            e_n = int'(eng_N_in);
                            e_dly = $urandom_range(0, 3);
                            e_st = 1;
                        end
                    end else if (noise_en && !busy &&
                                 $urandom_range(0, 3) == 0) begin
                        eng_sum_valid = 1'b1;
                        eng_sum = SW'($urandom);
                    end
                end
                1: begin
                    eng_ready = 1'b0;
                    if (!busy) begin
                        e_st = 0;
                    end else if (!eng_dead) begin
                        if (e_dly == 0) begin
                            eng_sum_valid = 1'b1;
                            eng_sum = SW'(e_n * (e_n + 1) / 2);
                            e_st = 2;
                        end else begin
                            e_dly--;
                        end
                    end
                end
                default: begin
                    if (eng_ack) begin
                        eng_sum_valid = 1'b0;
                        eng_sum = SW'($urandom);
                        e_st = 0;
                    end
                end
            endcase
        end
    end

    function automatic int tri_sum(input int n);
        int s;
        s = 0;
        for (int k = 1; k <= n; k++) s += k;
        return s;
    endfunction

    task automatic q_clear();
        for (int i = 0; i < NREQ; i++) begin
            qhead[i] = 0;
            qlen[i] = 0;
        end
    endtask

    task automatic q_push(input int i, input int v);
        qbuf[i][qhead[i] + qlen[i]] = v;
        qlen[i]++;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req_valid = '0;
        req_n = '0;
        rsp_ack = '0;
        eng_dead = 1'b0;
        noise_en = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        last_owner = NREQ - 1;
        @(negedge clk);
    endtask

    // Drives the queued requests and checks every grant, engine issue
    // and response against the round-robin queue model.
    task automatic run_stream(input string tag, input bit gate,
                              input int ack_fix);
        logic [NREQ-1:0] pend;
        int cyc, w, j, exp_id, exp_n, exp_sum, ack_wait, acks, hold;
        bit idle_known, ack_sent, work;
        cyc = 0;
        exp_id = -1;
        exp_n = 0;
        exp_sum = 0;
        ack_wait = 0;
        acks = 0;
        hold = 0;
        idle_known = 1'b1;
        ack_sent = 1'b0;
        olog.delete();
        sum_log.delete();
        hold_log.delete();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = (qlen[i] > 0);
            req_n[i*NW +: NW] = (qlen[i] > 0) ?
                                NW'(qbuf[i][qhead[i]]) : '0;
        end
        work = 1'b1;
        while (work && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            pend = req_valid;
            if (idle_known && pend != '0) begin
                w = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    j = (last_owner + k) % NREQ;
                    if (w < 0 && pend[j]) w = j;
                end
                cmp_cnt++;
                if (req_ready !== NREQ'(1 << w)) begin
                    bad_cnt++;
                    $display("FAIL %s grant: req_ready=%b, want id %0d (pend=%b)",
                             tag, req_ready, w, pend);
                    req_valid = '0;
                    rsp_ack = '0;
                    return;
                end
                exp_id = w;
                exp_n = qbuf[w][qhead[w]];
                exp_sum = tri_sum(exp_n);
                qhead[w]++;
                qlen[w]--;
                olog.push_back(w);
                acks = 0;
                hold = 0;
                idle_known = 1'b0;
                ack_wait = (ack_fix >= 0) ? ack_fix : $urandom_range(0, 4);
            end else begin
                cmp_cnt++;
                if (req_ready !== '0) begin
                    bad_cnt++;
                    $display("FAIL %s stray grant: req_ready=%b, want 0000",
                             tag, req_ready);
                end
            end
            if (eng_N_valid) begin
                cmp_cnt++;
                if (exp_id < 0 || eng_N_in !== NW'(exp_n)) begin
                    bad_cnt++;
                    $display("FAIL %s eng_N_in: got %0d, want %0d",
                             tag, eng_N_in, exp_n);
                end
            end
            if (eng_ack) acks++;
            if (ack_sent) begin
                cmp_cnt++;
                if (rsp_valid !== '0 || acks != 1) begin
                    bad_cnt++;
                    $display("FAIL %s done: rsp_valid=%b eng_acks=%0d, want 0000 and 1",
                             tag, rsp_valid, acks);
                end
                hold_log.push_back(hold);
                last_owner = exp_id;
                exp_id = -1;
                idle_known = 1'b1;
                ack_sent = 1'b0;
                rsp_ack = '0;
            end else if (exp_id >= 0 && rsp_valid !== '0) begin
                if (hold == 0) sum_log.push_back(int'(rsp_sum));
                hold++;
                cmp_cnt++;
                if (rsp_valid !== NREQ'(1 << exp_id) ||
                    rsp_sum !== SW'(exp_sum) || rsp_err !== 1'b0) begin
                    bad_cnt++;
                    $display("FAIL %s rsp: valid=%b sum=%0d err=%b, want %b %0d 0",
                             tag, rsp_valid, rsp_sum, rsp_err,
                             NREQ'(1 << exp_id), exp_sum);
                end
                if (ack_wait == 0) begin
                    rsp_ack = NREQ'($urandom) | NREQ'(1 << exp_id);
                    ack_sent = 1'b1;
                end else begin
                    ack_wait--;
                    rsp_ack = NREQ'($urandom) & ~NREQ'(1 << exp_id);
                end
            end else begin
                rsp_ack = '0;
            end
            work = (exp_id >= 0);
            for (int i = 0; i < NREQ; i++) begin
                if (qlen[i] > 0) work = 1'b1;
                req_valid[i] = (qlen[i] > 0) &&
                               (!gate || $urandom_range(0, 3) != 0);
                req_n[i*NW +: NW] = (qlen[i] > 0) ?
                                    NW'(qbuf[i][qhead[i]]) : '0;
            end
        end
        req_valid = '0;
        rsp_ack = '0;
        if (work) begin
            cmp_cnt++;
            bad_cnt++;
            $display("FAIL %s timeout: stream still busy after %0d cycles",
                     tag, cyc);
        end
    endtask

    task automatic test_reset();
        #3;
        reset = 1'b0;
        req_valid = '1;
        req_n = '1;
        #1;
        cmp_cnt++;
        if ({req_ready, rsp_valid, eng_N_valid, eng_ack, busy} !== '0) begin
            bad_cnt++;
            $display("FAIL reset strobes: ready=%b valid=%b nv=%b ack=%b busy=%b, want 0",
                     req_ready, rsp_valid, eng_N_valid, eng_ack, busy);
        end
        cmp_cnt++;
        if ({rsp_sum, rsp_err, eng_N_in} !== '0) begin
            bad_cnt++;
            $display("FAIL reset data: sum=%0d err=%b n_in=%0d, want 0",
                     rsp_sum, rsp_err, eng_N_in);
        end
        repeat (3) @(negedge clk);
        cmp_cnt++;
        if (req_ready !== '0 || busy !== 1'b0) begin
            bad_cnt++;
            $display("FAIL reset hold: req_ready=%b busy=%b, want 0000 0",
                     req_ready, busy);
        end
        req_valid = '0;
        req_n = '0;
        reset = 1'b1;
        last_owner = NREQ - 1;
        @(negedge clk);
    endtask

    task automatic test_single();
        do_reset();
        q_clear();
        q_push(1, 3);
        run_stream("single", 1'b0, 0);
        cmp_cnt++;
        if (olog.size() != 1 || sum_log.size() != 1 ||
            olog[0] != 1 || sum_log[0] != 6) begin
            bad_cnt++;
            $display("FAIL single result: %0d grants, want id 1 with sum 6",
                     olog.size());
        end
    endtask

    task automatic test_all_four();
        do_reset();
        q_clear();
        for (int i = 0; i < NREQ; i++) q_push(i, i + 1);
        run_stream("all4", 1'b0, 2);
        cmp_cnt++;
        if (olog.size() != 4 || sum_log.size() != 4) begin
            bad_cnt++;
            $display("FAIL all4 count: %0d grants, want 4", olog.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                cmp_cnt++;
                if (olog[i] != i || sum_log[i] != (i + 1) * (i + 2) / 2) begin
                    bad_cnt++;
                    $display("FAIL all4 slot %0d: id %0d sum %0d, want id %0d",
                             i, olog[i], sum_log[i], i);
                end
            end
        end
    endtask

    task automatic test_n_edges();
        do_reset();
        q_clear();
        q_push(2, 0);
        q_push(2, 7);
        noise_en = 1'b1;
        run_stream("n_edges", 1'b0, 0);
        noise_en = 1'b0;
        cmp_cnt++;
        if (sum_log.size() != 2 || sum_log[0] != 0 || sum_log[1] != 28) begin
            bad_cnt++;
            $display("FAIL n_edges sums: %0d results, want 0 then 28",
                     sum_log.size());
        end
    endtask

    task automatic test_owner_hold();
        do_reset();
        q_clear();
        q_push(0, 5);
        q_push(2, 6);
        run_stream("hold", 1'b0, 10);
        cmp_cnt++;
        if (hold_log.size() != 2 || hold_log[0] != 11 ||
            olog.size() != 2 || olog[1] != 2) begin
            bad_cnt++;
            $display("FAIL hold: %0d results, want 2 with 11 valid cycles each",
                     hold_log.size());
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        do_reset();
        q_clear();
        q_push(0, 2);
        run_stream("mid_pre", 1'b0, 0);
        eng_dead = 1'b1;
        req_valid[3] = 1'b1;
        req_n[3*NW +: NW] = 3'd5;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (req_ready[3]) req_valid[3] = 1'b0;
            if (busy && !eng_N_valid && !eng_ack && rsp_valid === '0)
                seen = 1'b1;
        end
        cmp_cnt++;
        if (!seen) begin
            bad_cnt++;
            $display("FAIL mid reach_wait: busy=%b, want engine wait phase",
                     busy);
        end
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        cmp_cnt++;
        if ({req_ready, rsp_valid, eng_N_valid, eng_ack, busy,
             rsp_sum, rsp_err, eng_N_in} !== '0) begin
            bad_cnt++;
            $display("FAIL mid reset: busy=%b sum=%0d valid=%b, want all 0",
                     busy, rsp_sum, rsp_valid);
        end
        @(negedge clk);
        reset = 1'b1;
        eng_dead = 1'b0;
        req_valid = '0;
        last_owner = NREQ - 1;
        @(negedge clk);
        q_clear();
        q_push(0, 1);
        q_push(3, 6);
        run_stream("mid_post", 1'b0, 0);
        cmp_cnt++;
        if (olog.size() != 2 || olog[0] != 0) begin
            bad_cnt++;
            $display("FAIL mid priority: first id %0d, want 0",
                     (olog.size() > 0) ? olog[0] : -1);
        end
    endtask

`ifdef SUM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int t0, t1, acks;
        do_reset();
        q_clear();
        q_push(2, 7);
        run_stream("to_pre", 1'b0, 0);
        t0 = -1;
        t1 = -1;
        acks = 0;
        eng_dead = 1'b1;
        req_valid[1] = 1'b1;
        req_n[1*NW +: NW] = 3'd4;
        for (int c = 0; c < 100 && t1 < 0; c++) begin
            @(negedge clk);
            if (req_ready[1] && t0 < 0) begin
                t0 = c;
                req_valid[1] = 1'b0;
            end
            if (eng_ack) acks++;
            if (rsp_valid !== '0) t1 = c;
        end
        cmp_cnt++;
        if (t0 < 0 || t1 - t0 != TO_CYCLES) begin
            bad_cnt++;
            $display("FAIL to latency: %0d cycles, want %0d",
                     t1 - t0, TO_CYCLES);
        end
        cmp_cnt++;
        if (rsp_valid !== 4'b0010 || rsp_err !== 1'b1 || rsp_sum !== '0) begin
            bad_cnt++;
            $display("FAIL to rsp: valid=%b err=%b sum=%0d, want 0010 1 0",
                     rsp_valid, rsp_err, rsp_sum);
        end
        cmp_cnt++;
        if (acks != 0) begin
            bad_cnt++;
            $display("FAIL to eng_ack: %0d pulses, want 0", acks);
        end
        rsp_ack = 4'b0010;
        @(negedge clk);
        rsp_ack = '0;
        cmp_cnt++;
        if (rsp_valid !== '0 || rsp_err !== 1'b0) begin
            bad_cnt++;
            $display("FAIL to clear: valid=%b err=%b, want 0000 0",
                     rsp_valid, rsp_err);
        end
        eng_dead = 1'b0;
        @(negedge clk);
    endtask
`endif

    task automatic test_random();
        int total;
        do_reset();
        for (int r = 0; r < 4; r++) begin
            q_clear();
            total = 0;
            for (int i = 0; i < NREQ; i++) begin
                for (int k = $urandom_range(0, 4); k > 0; k--) begin
                    q_push(i, $urandom_range(0, 7));
                    total++;
                end
            end
            noise_en = 1'b1;
            run_stream("random", 1'b1, -1);
            noise_en = 1'b0;
            cmp_cnt++;
            if (olog.size() != total) begin
                bad_cnt++;
                $display("FAIL random round %0d: %0d grants, want %0d",
                         r, olog.size(), total);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_n_edges();
        test_owner_hold();
        test_reset_mid();
`ifdef SUM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 cmp_cnt, bad_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
